// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: datapath width, canonical NOP encoding,
// default reset vector and the fetch-queue entry layout.
package cpu_pkg;

    localparam int unsigned     XLEN             = 32;
    localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    // One prefetched instruction together with the address it came from.
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch queue of fetch entries.
// Ports:
//   clk, rst   clock; synchronous active-low reset
//   i_push     write i_data at the tail (ignored when full, unless popping)
//   i_pop      retire the head entry (ignored when empty)
//   i_flush    discard all entries; wins over push/pop
//   i_data     entry to push
//   o_count    current occupancy (0..DEPTH)
//   o_head     registered head entry; holds until popped
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PW    = $clog2(DEPTH),
    localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output logic [CW-1:0] o_count,
    output fetch_entry_t o_head
);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic w_do_pop;
    logic w_do_push;

    assign w_do_pop  = i_pop && (r_count != '0);
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Storage is cleared on reset so the head reads as zero until first fill.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[PW'(i)] <= '0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front-end: owns the fetch PC, issues word requests to
// instruction memory, queues returned instructions with their PCs and hands
// them to decode over valid/ready. A redirect flushes the queue and turns
// every in-flight request into a stale one whose response is discarded.
// Ports:
//   clk, rst                      clock; synchronous active-low reset
//   imem_req_valid/ready/addr     fetch request channel (addr word-aligned)
//   imem_rsp_valid/data           in-order responses, no backpressure
//   redirect_valid/pc             flush and restart fetch at redirect_pc
//   out_valid/ready/pc/instr      head entry to decode
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned     XLEN     = cpu_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = cpu_pkg::RESET_PC_DEFAULT,
    parameter int unsigned     DEPTH    = 4
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_instr
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_rsp_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_cnt;

    logic [CW-1:0]   w_count;
    logic [CW+1:0]   w_inflight;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_req_fire;
    logic            w_rsp_live;
    logic            w_rsp_drop;
    logic            w_pop;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;

    // Queue slots plus every request still owed a response, live or stale;
    // issue stops once that total reaches DEPTH so the queue never overflows.
    assign w_inflight = {2'b00, w_count} + {2'b00, r_outstanding} + {2'b00, r_drop_cnt};

    assign w_redirect_pc  = redirect_pc & ~XLEN'(3);
    assign imem_req_valid = rst && !redirect_valid && (w_inflight < (CW+2)'(DEPTH));
    assign imem_req_addr  = r_pc;

    assign w_req_fire = imem_req_valid && imem_req_ready;
    assign w_rsp_drop = imem_rsp_valid && (r_drop_cnt != '0);
    assign w_rsp_live = imem_rsp_valid && (r_drop_cnt == '0);
    assign w_pop      = out_valid && out_ready;

    assign w_push_entry.pc    = r_rsp_pc;
    assign w_push_entry.instr = imem_rsp_data;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc          <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else if (redirect_valid) begin
            // Live requests become stale; a response arriving this cycle
            // settles one of them, whichever counter it would have hit.
            r_pc          <= w_redirect_pc;
            r_rsp_pc      <= w_redirect_pc;
            r_outstanding <= '0;
            r_drop_cnt    <= r_drop_cnt + r_outstanding - CW'(imem_rsp_valid);
        end else begin
            if (w_req_fire) begin
                r_pc <= r_pc + XLEN'(4);
            end
            if (w_rsp_live) begin
                r_rsp_pc <= r_rsp_pc + XLEN'(4);
            end
            r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_rsp_live);
            if (w_rsp_drop) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rsp_live && !redirect_valid),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  (w_push_entry),
        .o_count (w_count),
        .o_head  (w_head)
    );

    assign out_valid = (w_count != '0);
    assign out_pc    = w_head.pc;
    assign out_instr = w_head.instr;

    // Memory must never answer a request that was never made.
    a_rsp_expected: assert property (@(posedge clk) disable iff (!rst)
        imem_rsp_valid |-> ((r_drop_cnt != '0) || (r_outstanding != '0)));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    localparam int unsigned DEP    = 4;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data  = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc    = '0;
    logic        out_valid;
    logic        out_ready      = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_instr;

    always #5 clk = ~clk;

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC),
        .DEPTH    (DEP)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_instr      (out_instr)
    );

    // Memory-side bookkeeping: each accepted request, the redirect epoch it
    // was issued in and the cycle its response is due.
    typedef struct {
        logic [31:0] addr;
        int unsigned epoch;
        int unsigned due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    mreq_t       memq[$];
    ent_t        mq[$];
    logic [31:0] pop_log[$];
    logic [31:0] acc_log[$];

    int unsigned cyc      = 0;
    int unsigned epoch    = 0;
    int unsigned last_due = 0;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;
    int unsigned n_acc    = 0;
    logic [31:0] exp_addr = RST_PC;
    bit          was_reset = 1'b0;
    bit          popped    = 1'b0;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT against the model, advance
    // the model by the events of the coming edge.
    task automatic run_cycle(input bit rn, input bit ordy, input bit qrdy,
                             input bit redir, input logic [31:0] tgt);
        bit          exp_rv;
        bit          rsp;
        mreq_t       head;
        int unsigned d;
        rst            = rn;
        out_ready      = ordy;
        imem_req_ready = qrdy;
        redirect_valid = redir && rn;
        redirect_pc    = tgt;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        rsp            = 1'b0;
        if (rn && memq.size() != 0 && memq[0].due <= cyc) begin
            rsp            = 1'b1;
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memf(memq[0].addr);
        end
        #1;
        popped = 1'b0;
        exp_rv = rn && !redirect_valid && ((mq.size() + memq.size()) < DEP);
        if (!rn) begin
            check("req_valid_in_reset", {31'b0, imem_req_valid}, 32'd0);
        end else begin
            if (was_reset) begin
                check("reset_out_pc", out_pc, 32'd0);
                check("reset_out_instr", out_instr, 32'd0);
            end
            check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_rv});
            check("req_addr", imem_req_addr, exp_addr);
            check("out_valid", {31'b0, out_valid}, {31'b0, (mq.size() != 0)});
            if (mq.size() != 0) begin
                check("out_pc", out_pc, mq[0].pc);
                check("out_instr", out_instr, mq[0].instr);
            end
            if (imem_req_valid && imem_req_ready) acc_log.push_back(imem_req_addr);
            if (out_valid && out_ready) pop_log.push_back(out_pc);
        end

        if (!rn) begin
            memq.delete();
            mq.delete();
            exp_addr = RST_PC;
            last_due = 0;
            epoch++;
        end else begin
            if (rsp) head = memq.pop_front();
            if (redirect_valid) begin
                mq.delete();
                epoch++;
                exp_addr = tgt & ~32'h3;
            end else begin
                if (mq.size() != 0 && ordy) begin
                    void'(mq.pop_front());
                    popped = 1'b1;
                end
                if (rsp && head.epoch == epoch) mq.push_back('{head.addr, memf(head.addr)});
                if (exp_rv && qrdy) begin
                    d = cyc + $urandom_range(lat_max, lat_min);
                    if (d <= last_due) d = last_due + 1;
                    last_due = d;
                    memq.push_back('{exp_addr, epoch, d});
                    exp_addr = exp_addr + 32'd4;
                    n_acc++;
                end
            end
        end
        was_reset = !rn;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int unsigned n);
        repeat (n) run_cycle(1'b0, 1'b1, 1'b1, 1'b0, '0);
    endtask

    logic [31:0] tgts [6];

    initial begin
        int pops;
        bit ordy;
        bit qrdy;
        bit redir;
        bit rn;
        logic [31:0] t;

        tgts[0] = 32'h0000_0100; tgts[1] = 32'h0000_0203; tgts[2] = 32'hFFFF_FFF8;
        tgts[3] = 32'h8000_0001; tgts[4] = 32'h0000_0040; tgts[5] = 32'h1234_5676;

        // Streaming with a 1-cycle memory.
        lat_min = 1; lat_max = 1;
        do_reset(3);
        acc_log.delete(); pop_log.delete();
        repeat (6) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("first_req", acc_log.size() > 2 ? acc_log[0] : 32'hDEAD_BEEF, 32'h0);
        check("second_req", acc_log.size() > 2 ? acc_log[1] : 32'hDEAD_BEEF, 32'h4);
        check("third_req", acc_log.size() > 2 ? acc_log[2] : 32'hDEAD_BEEF, 32'h8);
        check("first_pop", pop_log.size() > 2 ? pop_log[0] : 32'hDEAD_BEEF, 32'h0);
        check("third_pop", pop_log.size() > 2 ? pop_log[2] : 32'hDEAD_BEEF, 32'h8);
        pops = 0;
        repeat (10) begin
            run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
            if (popped) pops++;
        end
        check("throughput", pops, 10);

        // Decode stall fills the queue, then drains in order.
        do_reset(2);
        acc_log.delete(); pop_log.delete();
        repeat (10) run_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        check("stall_accepts", acc_log.size(), 4);
        check("stall_full_no_req", {31'b0, imem_req_valid}, 32'd0);
        acc_log.delete();
        repeat (8) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("resume_addr", acc_log.size() != 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h10);
        check("drain_pc3", pop_log.size() > 3 ? pop_log[3] : 32'hDEAD_BEEF, 32'hC);

        // 3-cycle memory, redirect with requests in flight.
        lat_min = 3; lat_max = 3;
        do_reset(2);
        repeat (3) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        pop_log.delete();
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0103);
        check("flush_after_redirect", {31'b0, out_valid}, 32'd0);
        repeat (15) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("redirect_first_pop", pop_log.size() != 0 ? pop_log[0] : 32'hDEAD_BEEF, 32'h100);

        // Redirect coinciding with a response and a decode handshake.
        lat_min = 1; lat_max = 1;
        do_reset(2);
        repeat (6) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        acc_log.delete();
        run_cycle(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0100);
        check("flush_same_cycle", {31'b0, out_valid}, 32'd0);
        repeat (4) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("redirect_next_req", acc_log.size() != 0 ? acc_log[0] : 32'hDEAD_BEEF, 32'h100);

        // Memory not ready; redirect while the request is pending.
        repeat (5) run_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0200);
        run_cycle(1'b1, 1'b1, 1'b0, 1'b0, '0);
        check("stall_redirect_addr", imem_req_addr, 32'h200);
        repeat (4) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);

        // Reset while three entries are queued.
        do_reset(1);
        repeat (4) run_cycle(1'b1, 1'b0, 1'b1, 1'b0, '0);
        pop_log.delete();
        do_reset(1);
        check("reset_clears_valid", {31'b0, out_valid}, 32'd0);
        repeat (6) run_cycle(1'b1, 1'b1, 1'b1, 1'b0, '0);
        check("restart_pop", pop_log.size() != 0 ? pop_log[0] : RST_PC + 32'h1, RST_PC);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat_min = 1;
                lat_max = $urandom_range(4, 1);
            end
            ordy  = ($urandom_range(99, 0) < 75);
            qrdy  = ($urandom_range(99, 0) < 80);
            redir = ($urandom_range(99, 0) < 4);
            rn    = ($urandom_range(999, 0) >= 5);
            t     = ($urandom_range(1, 0) == 1) ? tgts[$urandom_range(5, 0)] : $urandom();
            run_cycle(rn, ordy, qrdy, redir, t);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch front-end of the cpu core; owns the architectural fetch PC and issues word requests to instruction memory. Buffers returned instructions with their PCs in a small in-order prefetch queue and presents them to decode over a valid/ready handshake. A redirect from execute (branch/jump taken) flushes the queue and discards stale in-flight responses.

Parameters:
XLEN, 32, address/instruction width
RESET_PC, 32'h0000_0000, first fetch address after reset
DEPTH, 4, prefetch queue entries; also bounds total in-flight requests (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-low
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  XLEN  word-aligned fetch address
imem_rsp_valid  in  1  response data valid (in order, no backpressure)
imem_rsp_data  in  XLEN  instruction word
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  XLEN  new fetch PC (bits[1:0] ignored, treated as 0)
out_valid  out  1  head entry valid to decode
out_ready  in  1  decode accepts head entry
out_pc  out  XLEN  PC of head entry
out_instr  out  XLEN  instruction of head entry

Behaviour:
- Reset (rst==0 at posedge): pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0. Outputs during/after reset: imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_pc=0, out_instr=0. Reset mid-operation discards everything; responses for pre-reset requests are not tracked (memory is reset together with the core).
- Counters: count (queue occupancy), outstanding (live requests), drop_cnt (stale requests); each $clog2(DEPTH+1) bits; invariant count+outstanding+drop_cnt <= DEPTH.
- Issue: imem_req_valid = rst && !redirect_valid && (count+outstanding+drop_cnt < DEPTH); imem_req_addr = pc. On req_valid&&req_ready: outstanding+1, pc+=4 (wraps modulo 2^XLEN). While unaccepted, addr holds stable; only a redirect may withdraw a pending request.
- Response: on imem_rsp_valid: if drop_cnt>0, decrement drop_cnt, data discarded; else outstanding-1, push {rsp_pc, data} into queue, rsp_pc+=4. rsp_pc tracks the PC of the next expected live response; it is set to RESET_PC at reset and to redirect_pc on redirect.
- Output: out_valid = count!=0; out_pc/out_instr = head entry (registered, hold when not popped). Pop on out_valid&&out_ready. Simultaneous push and pop keeps count unchanged. Queue cannot overflow by construction; response with drop_cnt==0 and outstanding==0 is a protocol error (assertion).
- Latency: first request the cycle after rst deasserts; response at edge N -> out_valid high in cycle N+1. With 1-cycle memory and out_ready=1: sustained one instruction per cycle.
- Redirect (takes priority over all same-cycle events): at the edge, queue flushed (count=0), pc=rsp_pc=redirect_pc&~3, drop_cnt = drop_cnt + outstanding - (response this cycle ? 1 : 0), outstanding=0. imem_req_valid forced 0 that cycle; a same-cycle pop is honored by decode but the entry is gone anyway; a same-cycle response is discarded. Back-to-back redirects: the last one wins.
- Stall: out_ready=0 fills queue, then issue stops once count+outstanding reaches DEPTH; no response is ever lost.

Decomposition:
- cpu_pkg: XLEN, NOP_INSTR (32'h0000_0013), RESET_PC default, fetch-entry struct typedef {pc, instr}.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch entries with push, pop, flush, count, head outputs; pointers wrap modulo DEPTH.

Test Plan:
- Reset release, memory 1-cycle, out_ready=1 -> requests 0x0,0x4,0x8 on consecutive cycles; out_pc 0x0,0x4,0x8 one per cycle with matching instr.
- out_ready=0 for 10 cycles, 1-cycle memory -> exactly 4 requests issued, queue full, req_valid=0; release -> 0x0..0xC drain in order, fetch resumes at 0x10.
- Memory 3-cycle latency, redirect to 0x100 with 2 outstanding -> both stale responses dropped; first out_pc=0x100; no 0x8/0xC delivered.
- Redirect in same cycle as a response and an out handshake -> queue empty next cycle, drop_cnt = outstanding-1, next request addr 0x100.
- imem_req_ready low 5 cycles -> imem_req_addr stable; redirect during stall -> req_valid drops one cycle, then addr=redirect_pc.
- rst asserted while queue holds 3 entries -> next cycle out_valid=0, req_addr=RESET_PC; fetch restarts at RESET_PC.
